// File: rtl/sterownik_pkg.sv
// Shared definitions for the PLC scan-cycle controller.
// State encoding and default timing parameters.
package sterownik_pkg;

  localparam int STAN_W          = 3;
  localparam int CYKL_W_DEF      = 16;
  localparam int WDT_LIMIT_DEF   = 200;
  localparam int SCAN_PERIOD_DEF = 0;

  typedef enum logic [STAN_W-1:0] {
    S_IDLE       = 3'd0,
    S_RESET_PC   = 3'd1,
    S_SAMPLE_IN  = 3'd2,
    S_EXECUTE    = 3'd3,
    S_UPDATE_OUT = 3'd4,
    S_WAIT       = 3'd5,
    S_FAULT      = 3'd6
  } stan_t;

endpackage

// File: rtl/sterownik_cyklu_watchdog.sv
// Execute-cycle counter for the scan controller watchdog.
// Saturating count with clear, enable and limit-hit flag.
module licznik_watchdog #(
  parameter int W     = 16,
  parameter int LIMIT = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         hit
);

  localparam logic [W-1:0] LIM_M1  = W'(LIMIT - 1);
  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and hold at max.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign hit = (cnt_q == LIM_M1);

endmodule

// File: rtl/sterownik_cyklu.sv
// Scan-cycle controller for the 8-bit PLC processor.
// Optional SCAN_STATS_EN adds max_wykon / przekroczenie stats.
module sterownik_cyklu
  import sterownik_pkg::*;
#(
  parameter int CYKL_W      = CYKL_W_DEF,
  parameter int WDT_LIMIT   = WDT_LIMIT_DEF,
  parameter int SCAN_PERIOD = SCAN_PERIOD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              koniec_prog,
  input  logic              kasuj_blad,
  output logic              proc_rst,
  output logic              proc_en,
  output logic              ce_wejsc,
  output logic              zatwierdz_wyjsc,
  output logic              blad_wdt,
  output logic [CYKL_W-1:0] licznik_skanow,
  output logic [STAN_W-1:0] stan
`ifdef SCAN_STATS_EN
  ,
  output logic [CYKL_W-1:0] max_wykon,
  output logic              przekroczenie
`endif
);

  localparam logic [CYKL_W-1:0] TMR_MAX = '1;

  stan_t             state_q, state_d;
  logic [CYKL_W-1:0] timer_q, timer_d;
  logic [CYKL_W-1:0] skan_q, skan_d;
  logic              proc_rst_q, proc_rst_d;
  logic              proc_en_q, proc_en_d;
  logic              ce_q, ce_d;
  logic              zat_q, zat_d;
  logic              blad_q, blad_d;
  logic              pad;
  logic [CYKL_W-1:0] wdt_cnt;
  logic              wdt_hit;

  licznik_watchdog #(
    .W     (CYKL_W),
    .LIMIT (WDT_LIMIT)
  ) u_wdt (
    .clk (clk),
    .rst (rst),
    .clr (state_q == S_SAMPLE_IN),
    .en  (state_q == S_EXECUTE),
    .cnt (wdt_cnt),
    .hit (wdt_hit)
  );

  // Padding needed while the scan is shorter than the period.
  always_comb begin
    pad = 1'b0;
    if (SCAN_PERIOD != 0) begin
      pad = (int'(timer_q) < SCAN_PERIOD - 1);
    end
  end

  // Next-state logic of the scan sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RESET_PC;
      end
      S_RESET_PC:  state_d = S_SAMPLE_IN;
      S_SAMPLE_IN: state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (koniec_prog) begin
          state_d = S_UPDATE_OUT;
        end else if (wdt_hit) begin
          state_d = S_FAULT;
        end
      end
      S_UPDATE_OUT, S_WAIT: begin
        if (pad) begin
          state_d = S_WAIT;
        end else if (start) begin
          state_d = S_RESET_PC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        if (kasuj_blad && !start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the next state, then registered.
  always_comb begin
    proc_rst_d = 1'b0;
    proc_en_d  = 1'b0;
    ce_d       = 1'b0;
    zat_d      = 1'b0;
    blad_d     = 1'b0;
    unique case (1'b1)
      (state_d == S_IDLE),
      (state_d == S_RESET_PC):   proc_rst_d = 1'b1;
      (state_d == S_SAMPLE_IN):  ce_d       = 1'b1;
      (state_d == S_EXECUTE):    proc_en_d  = 1'b1;
      (state_d == S_UPDATE_OUT): zat_d      = 1'b1;
      (state_d == S_FAULT): begin
        proc_rst_d = 1'b1;
        blad_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // Scan timer restarts at RESET_PC and saturates; scan count wraps.
  always_comb begin
    if (state_d == S_RESET_PC) begin
      timer_d = '0;
    end else if (timer_q != TMR_MAX) begin
      timer_d = timer_q + CYKL_W'(1);
    end else begin
      timer_d = timer_q;
    end
    skan_d = skan_q;
    if (state_q == S_UPDATE_OUT) begin
      skan_d = skan_q + CYKL_W'(1);
    end
  end

  // State, timer, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      skan_q     <= '0;
      proc_rst_q <= 1'b1;
      proc_en_q  <= 1'b0;
      ce_q       <= 1'b0;
      zat_q      <= 1'b0;
      blad_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      skan_q     <= skan_d;
      proc_rst_q <= proc_rst_d;
      proc_en_q  <= proc_en_d;
      ce_q       <= ce_d;
      zat_q      <= zat_d;
      blad_q     <= blad_d;
    end
  end

  assign proc_rst        = proc_rst_q;
  assign proc_en         = proc_en_q;
  assign ce_wejsc        = ce_q;
  assign zatwierdz_wyjsc = zat_q;
  assign blad_wdt        = blad_q;
  assign licznik_skanow  = skan_q;
  assign stan            = state_q;

`ifdef SCAN_STATS_EN
  logic [CYKL_W-1:0] max_q, max_d;
  logic              prz_q, prz_d;

  // Track longest execute phase and period overruns at commit.
  always_comb begin
    max_d = max_q;
    prz_d = prz_q;
    if (state_q == S_UPDATE_OUT) begin
      if (wdt_cnt > max_q) max_d = wdt_cnt;
      if ((SCAN_PERIOD != 0) && (int'(wdt_cnt) + 3 > SCAN_PERIOD)) begin
        prz_d = 1'b1;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q <= '0;
      prz_q <= 1'b0;
    end else begin
      max_q <= max_d;
      prz_q <= prz_d;
    end
  end

  assign max_wykon     = max_q;
  assign przekroczenie = prz_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^wdt_cnt;
`endif

endmodule

// File: tb/tb_sterownik_cyklu.sv
// Bench for sterownik_cyklu: two instances, free-running and
// padded to 20 cycles, checked against a per-scan timeline model.
module tb_sterownik_cyklu;

  localparam int WDT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  start, kon, kas;
  logic [1:0]  prst, pen, ce, zat, blad;
  logic [2:0]  stan0, stan1;
  logic [15:0] cnt0, cnt1;

  int total  = 0;
  int passed = 0;
  int exp_cnt[2];

  always #5 clk = ~clk;

  sterownik_cyklu #(
    .CYKL_W(16), .WDT_LIMIT(WDT), .SCAN_PERIOD(0)
  ) u0 (
    .clk(clk), .rst(rst), .start(start[0]),
    .koniec_prog(kon[0]), .kasuj_blad(kas[0]),
    .proc_rst(prst[0]), .proc_en(pen[0]),
    .ce_wejsc(ce[0]), .zatwierdz_wyjsc(zat[0]),
    .blad_wdt(blad[0]), .licznik_skanow(cnt0),
    .stan(stan0)
  );

  sterownik_cyklu #(
    .CYKL_W(16), .WDT_LIMIT(WDT), .SCAN_PERIOD(20)
  ) u1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .koniec_prog(kon[1]), .kasuj_blad(kas[1]),
    .proc_rst(prst[1]), .proc_en(pen[1]),
    .ce_wejsc(ce[1]), .zatwierdz_wyjsc(zat[1]),
    .blad_wdt(blad[1]), .licznik_skanow(cnt1),
    .stan(stan1)
  );

  function automatic logic [7:0] obs(int id);
    if (id == 1)
      return {stan1, prst[1], pen[1], ce[1], zat[1], blad[1]};
    return {stan0, prst[0], pen[0], ce[0], zat[0], blad[0]};
  endfunction

  function automatic logic [15:0] cnt_of(int id);
    return (id == 1) ? cnt1 : cnt0;
  endfunction

  task automatic chk(string tag, logic [15:0] o, logic [15:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  task automatic chk_st(int id, string tag, logic [2:0] s,
                        bit pr, bit en, bit c, bit z, bit b);
    logic [7:0] e;
    e = {s, pr, en, c, z, b};
    chk($sformatf("%s[%0d]", tag, id), {8'h0, obs(id)}, {8'h0, e});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // From IDLE, raise start and land on RESET_PC.
  task automatic go(int id);
    chk_st(id, "idle_pre", 3'd0, 1, 0, 0, 0, 0);
    start[id] = 1'b1;
    cyc();
  endtask

  // One scan whose program runs n cycles; start set to st_after
  // during the first execute cycle. Sampled cycle is RESET_PC.
  task automatic scan(int id, int n, bit st_after);
    int per;
    int len;
    int lim;
    per = (id == 1) ? 20 : 0;
    len = (n + 3 > per) ? n + 3 : per;
    lim = (n > WDT) ? WDT : n;
    chk_st(id, "reset_pc", 3'd1, 1, 0, 0, 0, 0);
    cyc();
    chk_st(id, "sample_in", 3'd2, 0, 0, 1, 0, 0);
    for (int k = 1; k <= lim; k++) begin
      cyc();
      if (k == 1) start[id] = st_after;
      chk_st(id, "execute", 3'd3, 0, 1, 0, 0, 0);
      if (k == n) kon[id] = 1'b1;
    end
    if (n > WDT) begin
      cyc();
      chk_st(id, "fault", 3'd6, 1, 0, 0, 0, 1);
      chk($sformatf("cnt_fault[%0d]", id), cnt_of(id),
          16'(exp_cnt[id]));
      return;
    end
    cyc();
    kon[id] = 1'b0;
    chk_st(id, "update_out", 3'd4, 0, 0, 0, 1, 0);
    exp_cnt[id]++;
    for (int w = 0; w < len - n - 3; w++) begin
      cyc();
      chk_st(id, "wait", 3'd5, 0, 0, 0, 0, 0);
    end
    cyc();
    chk($sformatf("count[%0d]", id), cnt_of(id),
        16'(exp_cnt[id]));
    if (st_after)
      chk_st(id, "next_scan", 3'd1, 1, 0, 0, 0, 0);
    else
      chk_st(id, "end_idle", 3'd0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = '0;
    kon = '0;
    kas = '0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    cyc();
    cyc();
    chk_st(0, "reset", 3'd0, 1, 0, 0, 0, 0);
    chk_st(1, "reset", 3'd0, 1, 0, 0, 0, 0);
    chk("reset_cnt0", cnt0, 16'd0);
    chk("reset_cnt1", cnt1, 16'd0);
    rst = 1'b0;
    cyc();

    // Basic free-running scans, then padded scans.
    go(0);
    scan(0, 4, 1);
    scan(0, 4, 0);
    go(1);
    scan(1, 4, 1);
    scan(1, 4, 0);

    // Random program lengths on both instances.
    for (int id = 0; id < 2; id++) begin
      go(id);
      for (int i = 0; i < 6; i++) begin
        scan(id, int'($urandom_range(1, WDT)), i < 5);
      end
    end

    // Watchdog trap, ignored clear, then real clear.
    go(0);
    scan(0, 100, 1);
    cyc();
    chk_st(0, "fault_hold", 3'd6, 1, 0, 0, 0, 1);
    kas[0] = 1'b1;
    cyc();
    chk_st(0, "kas_ignored", 3'd6, 1, 0, 0, 0, 1);
    kas[0] = 1'b0;
    start[0] = 1'b0;
    cyc();
    chk_st(0, "fault_nostart", 3'd6, 1, 0, 0, 0, 1);
    kas[0] = 1'b1;
    cyc();
    kas[0] = 1'b0;
    chk_st(0, "fault_clr", 3'd0, 1, 0, 0, 0, 0);
    chk("cnt_after_fault", cnt0, 16'(exp_cnt[0]));

    // Program ends exactly on the watchdog limit.
    go(0);
    scan(0, WDT, 0);

    // Reset in the middle of execution.
    go(0);
    cyc();
    cyc();
    cyc();
    chk_st(0, "pre_rst_exec", 3'd3, 0, 1, 0, 0, 0);
    rst = 1'b1;
    start[0] = 1'b0;
    cyc();
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    chk_st(0, "mid_rst", 3'd0, 1, 0, 0, 0, 0);
    chk("mid_rst_cnt0", cnt0, 16'(exp_cnt[0]));
    chk("mid_rst_cnt1", cnt1, 16'(exp_cnt[1]));
    rst = 1'b0;
    cyc();
    chk_st(0, "post_rst", 3'd0, 1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
